// File: rtl/soc_sysid_checker.sv
// Reads the sysid slave's ID and timestamp words over Avalon-MM and compares them against
// the build-time values. Any read that stalls too long is abandoned and the result reported as a failure.
module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h61E57043,
    parameter int unsigned TIMEOUT_CYCLES     = 16,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_RD_ID = 3'd1;
    localparam logic [2:0]  S_RD_TS = 3'd2;
    localparam logic [2:0]  S_CHECK = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;
    localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT_CYCLES);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_auto_pend;
    logic        r_m_read;
    logic        r_m_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic        r_id_got;
    logic        r_ts_got;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_captured_id;
    logic [31:0] r_captured_ts;

    logic        w_accept;
    logic        w_stall;
    logic [16:0] w_cnt_inc;
    logic        w_expire;
    logic        w_id_match;
    logic        w_ts_match;

    // Bus handshake qualifiers, timeout detection and word comparisons.
    always_comb begin
        w_accept   = r_m_read & ~m_waitrequest;
        w_stall    = r_m_read & m_waitrequest;
        w_cnt_inc  = {1'b0, r_wait_cnt} + 17'd1;
        w_expire   = w_stall & (w_cnt_inc == LP_TIMEOUT);
        w_id_match = r_id_got & (r_captured_id == EXPECTED_ID);
        w_ts_match = r_ts_got & (r_captured_ts == EXPECTED_TIMESTAMP);
    end

    // Next-state logic; a start seen while busy has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start || r_auto_pend) begin
                    w_state_nxt = S_RD_ID;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_ID: begin
                if (w_accept) begin
                    w_state_nxt = S_RD_TS;
                end else if (w_expire) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_RD_ID;
                end
            end
            S_RD_TS: begin
                if (w_accept || w_expire) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_RD_TS;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RD_ID;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, bus strobes, captured words and result flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_auto_pend   <= AUTO_START;
            r_m_read      <= 1'b0;
            r_m_address   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_got      <= 1'b0;
            r_ts_got      <= 1'b0;
            r_wait_cnt    <= 16'd0;
            r_captured_id <= 32'd0;
            r_captured_ts <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_auto_pend <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_state_nxt == S_RD_ID) begin
                        r_m_read    <= 1'b1;
                        r_m_address <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_id_ok     <= 1'b0;
                        r_ts_ok     <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_id_got    <= 1'b0;
                        r_ts_got    <= 1'b0;
                        r_wait_cnt  <= 16'd0;
                    end
                end
                S_RD_ID: begin
                    if (w_accept) begin
                        r_captured_id <= m_readdata;
                        r_id_got      <= 1'b1;
                        r_m_address   <= 1'b1;
                        r_wait_cnt    <= 16'd0;
                    end else if (w_expire) begin
                        // The timestamp read is skipped, so captured_ts keeps its old value.
                        r_m_read   <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_wait_cnt <= w_cnt_inc[15:0];
                    end else if (w_stall) begin
                        r_wait_cnt <= w_cnt_inc[15:0];
                    end
                end
                S_RD_TS: begin
                    if (w_accept) begin
                        r_captured_ts <= m_readdata;
                        r_ts_got      <= 1'b1;
                        r_m_read      <= 1'b0;
                    end else if (w_expire) begin
                        r_m_read   <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_wait_cnt <= w_cnt_inc[15:0];
                    end else if (w_stall) begin
                        r_wait_cnt <= w_cnt_inc[15:0];
                    end
                end
                S_CHECK: begin
                    r_id_ok <= w_id_match;
                    r_ts_ok <= w_ts_match;
                    r_pass  <= w_id_match & w_ts_match & ~r_timeout;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_m_read <= 1'b0;
                end
            endcase
        end
    end

    assign m_address   = r_m_address;
    assign m_read      = r_m_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign captured_id = r_captured_id;
    assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Scoreboard bench: two checker instances (auto-start on/off) driven by behavioral sysid slaves.
`timescale 1ns/1ps
module tb_soc_sysid_checker;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic        pass;
        logic [31:0] cid;
        logic [31:0] cts;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t a_q[$];
    exp_t b_q[$];

    logic        a_rst, a_start, a_m_address, a_m_read, a_wr;
    logic        a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout;
    logic [31:0] a_rdata, a_cid, a_cts, a_d0, a_d1;
    int          a_s0, a_s1, a_scnt = 0, a_rd1_cnt = 0;

    logic        b_rst, b_start, b_m_address, b_m_read, b_wr;
    logic        b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_timeout;
    logic [31:0] b_rdata, b_cid, b_cts, b_d0, b_d1;
    int          b_s0, b_s1, b_scnt = 0;

    soc_sysid_checker dut_a (
        .clock(clk), .reset(a_rst), .start(a_start),
        .m_address(a_m_address), .m_read(a_m_read), .m_readdata(a_rdata), .m_waitrequest(a_wr),
        .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
        .timeout(a_timeout), .captured_id(a_cid), .captured_ts(a_cts)
    );

    soc_sysid_checker #(.AUTO_START(1'b0)) dut_b (
        .clock(clk), .reset(b_rst), .start(b_start),
        .m_address(b_m_address), .m_read(b_m_read), .m_readdata(b_rdata), .m_waitrequest(b_wr),
        .busy(b_busy), .done(b_done), .pass(b_pass), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
        .timeout(b_timeout), .captured_id(b_cid), .captured_ts(b_cts)
    );

    // Slaves stall each read for a configurable number of cycles, then return the word.
    assign a_wr    = a_m_read && (a_scnt < (a_m_address ? a_s1 : a_s0));
    assign a_rdata = a_m_address ? a_d1 : a_d0;
    assign b_wr    = b_m_read && (b_scnt < (b_m_address ? b_s1 : b_s0));
    assign b_rdata = b_m_address ? b_d1 : b_d0;

    always @(posedge clk) begin
        a_scnt <= (a_m_read && a_wr) ? a_scnt + 1 : 0;
        b_scnt <= (b_m_read && b_wr) ? b_scnt + 1 : 0;
        if (a_m_read === 1'b1 && a_m_address === 1'b1) a_rd1_cnt <= a_rd1_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic i, input logic t, input logic o, input logic p,
                                input logic [31:0] ci, input logic [31:0] ct, input int lat);
        exp_t e;
        e.id_ok = i; e.ts_ok = t; e.to = o; e.pass = p;
        e.cid = ci; e.cts = ct; e.lat = lat; e.t0 = cyc;
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e, input logic i, input logic t,
                             input logic o, input logic p, input logic [31:0] ci, input logic [31:0] ct);
        chk({tag, "_id_ok"}, 32'(i), 32'(e.id_ok));
        chk({tag, "_ts_ok"}, 32'(t), 32'(e.ts_ok));
        chk({tag, "_timeout"}, 32'(o), 32'(e.to));
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_captured_id"}, ci, e.cid);
        chk({tag, "_captured_ts"}, ct, e.cts);
        chk({tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
    endtask

    task automatic chk_rst(input string tag, input logic [7:0] ctl, input logic [31:0] ci,
                           input logic [31:0] ct);
        chk({tag, "_rst_ctl"}, 32'(ctl), 32'd0);
        chk({tag, "_rst_cid"}, ci, 32'd0);
        chk({tag, "_rst_cts"}, ct, 32'd0);
    endtask

    // Monitors: pop one expectation per rising edge of done.
    logic a_done_q = 1'b0, b_done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (a_done === 1'b1 && a_done_q === 1'b0) begin
            if (a_q.size() == 0) begin
                chk("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = a_q.pop_front();
                check_res("a", e, a_id_ok, a_ts_ok, a_timeout, a_pass, a_cid, a_cts);
            end
        end
        a_done_q = a_done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_done === 1'b1 && b_done_q === 1'b0) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = b_q.pop_front();
                check_res("b", e, b_id_ok, b_ts_ok, b_timeout, b_pass, b_cid, b_cts);
            end
        end
        b_done_q = b_done;
    end

    // Strobes must hold while stalled and drop right after the 16th stalled cycle.
    logic a_prev_stall = 1'b0, a_prev_addr = 1'b0;
    int   a_run = 0;
    always @(negedge clk) begin
        if (a_prev_stall) begin
            if (a_run < 16) begin
                chk("a_hold_read", 32'(a_m_read), 32'd1);
                chk("a_hold_addr", 32'(a_m_address), 32'(a_prev_addr));
            end else begin
                chk("a_timeout_drop", 32'(a_m_read), 32'd0);
            end
        end
        a_prev_stall = (a_m_read === 1'b1) && (a_wr === 1'b1) && (a_rst === 1'b0);
        a_prev_addr  = a_m_address;
        a_run        = a_prev_stall ? a_run + 1 : 0;
    end

    task automatic drain_a();
        for (int i = 0; i < 400 && a_q.size() > 0; i++) @(negedge clk);
        chk("a_drain", 32'(a_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 400 && b_q.size() > 0; i++) @(negedge clk);
        chk("b_drain", 32'(b_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_a(input exp_t e);
        a_start = 1'b1;
        a_q.push_back(e);
        @(negedge clk);
        a_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        a_rst = 1'b1; a_start = 1'b0;
        a_d0 = 32'h00000000; a_d1 = 32'h61E57043; a_s0 = 0; a_s1 = 0;
        b_rst = 1'b1; b_start = 1'b0;
        b_d0 = 32'h12345678; b_d1 = 32'h61E57043; b_s0 = 0; b_s1 = 1000;
        repeat (3) @(negedge clk);
        chk_rst("a", {a_m_read, a_m_address, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout},
                a_cid, a_cts);

        // Auto-start after reset with a matching zero-wait slave.
        a_rst = 1'b0;
        a_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h61E57043, 4));
        drain_a();

        // Timestamp off by one in bit 0.
        a_d1 = 32'h61E57042;
        pulse_a(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h61E57042, 4));
        drain_a();

        // Restart from a failing DONE clears the result flags on the next cycle.
        a_d1 = 32'h61E57043;
        pulse_a(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h61E57043, 4));
        chk("a_restart_done", 32'(a_done), 32'd0);
        chk("a_restart_id_ok", 32'(a_id_ok), 32'd0);
        chk("a_restart_busy", 32'(a_busy), 32'd1);
        drain_a();

        // Three stall cycles on each read.
        a_s0 = 3; a_s1 = 3;
        pulse_a(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h61E57043, 10));
        drain_a();
        a_s0 = 0; a_s1 = 0;

        // ID differs only in bit 31.
        a_d0 = 32'h80000000;
        pulse_a(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'h61E57043, 4));
        drain_a();

        // ID read stuck in waitrequest: old captures survive, address 1 never read.
        a_s0 = 1000;
        snap = a_rd1_cnt;
        pulse_a(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000, 32'h61E57043, 18));
        drain_a();
        chk("a_addr1_untouched", 32'(a_rd1_cnt - snap), 32'd0);
        a_s0 = 0; a_d0 = 32'h00000000;

        // Start held through RD_ID acceptance and RD_TS: only one sequence runs.
        a_start = 1'b1;
        a_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h61E57043, 4));
        repeat (3) @(negedge clk);
        a_start = 1'b0;
        drain_a();
        repeat (6) @(negedge clk);
        chk("a_no_requeue_done", 32'(a_done), 32'd1);
        chk("a_no_requeue_read", 32'(a_m_read), 32'd0);

        // Instance without auto-start: idle after reset until start.
        b_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_idle_read", 32'(b_m_read), 32'd0);
        chk("b_idle_busy", 32'(b_busy), 32'd0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 20 && !(b_m_read === 1'b1 && b_m_address === 1'b1); i++) @(negedge clk);
        chk("b_reach_rd_ts", 32'(b_m_read && b_m_address), 32'd1);
        repeat (3) @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        chk_rst("b", {b_m_read, b_m_address, b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_timeout},
                b_cid, b_cts);
        b_rst = 1'b0;
        b_d0 = 32'h00000000; b_s1 = 0;
        repeat (5) @(negedge clk);
        chk("b_after_rst_read", 32'(b_m_read), 32'd0);
        chk("b_after_rst_done", 32'(b_done), 32'd0);
        b_start = 1'b1;
        b_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h61E57043, 4));
        @(negedge clk);
        b_start = 1'b0;
        drain_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/soc_sysid_checker.md
SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h00000000, system ID value required at word address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'h61E57043 (1642426435), timestamp required at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum cycles one read may stall on waitrequest; legal range 1..65535.
REQ-004 Parameter AUTO_START, default 1, when 1 a check sequence launches on the first cycle after reset deasserts.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to run a check sequence.
REQ-008 m_address  output  1  Avalon-MM word address to sysid slave.
REQ-009 m_read  output  1  Avalon-MM read strobe.
REQ-010 m_readdata  input  32  Avalon-MM read data, valid in the cycle m_read=1 and m_waitrequest=0.
REQ-011 m_waitrequest  input  1  slave stall; tie 0 for a zero-wait slave.
REQ-012 busy  output  1  high while a sequence is in progress.
REQ-013 done  output  1  high from sequence completion until the next sequence starts or reset.
REQ-014 pass  output  1  valid when done=1; high iff both words matched and no timeout occurred.
REQ-015 id_ok / ts_ok  output  1 each  per-word match flags, valid when done=1.
REQ-016 timeout  output  1  valid when done=1; high if any read exceeded TIMEOUT_CYCLES.
REQ-017 captured_id / captured_ts  output  32 each  last accepted read data for each address.

Function
REQ-018 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK, DONE.
REQ-019 IDLE -> RD_ID when start=1, or on the first post-reset cycle when AUTO_START=1; otherwise hold.
REQ-020 RD_ID: m_read=1, m_address=0; on m_waitrequest=0 capture m_readdata into captured_id and go to RD_TS next cycle.
REQ-021 RD_TS: m_read=1, m_address=1; on m_waitrequest=0 capture into captured_ts and go to CHECK.
REQ-022 m_address and m_read SHALL be registered outputs, held stable while m_waitrequest=1.
REQ-023 Zero-wait slave: sequence start to done=1 is exactly 4 cycles (RD_ID, RD_TS, CHECK, DONE).
REQ-024 A 16-bit wait counter SHALL clear on entry to each read state and increment each cycle m_waitrequest=1.
REQ-025 When the counter reaches TIMEOUT_CYCLES with m_waitrequest still 1, deassert m_read, set timeout, skip the remaining read, go to CHECK; the unread captured_* word keeps its previous value.
REQ-026 CHECK: id_ok = (captured_id == EXPECTED_ID) and read completed; ts_ok likewise; pass = id_ok & ts_ok & ~timeout; registered for DONE.
REQ-027 DONE: done=1, busy=0; start=1 re-enters RD_ID next cycle, clearing done, pass, id_ok, ts_ok, timeout.
REQ-028 busy=1 in RD_ID, RD_TS, CHECK; start while busy SHALL be ignored (no queueing).
REQ-029 start and an acceptance (m_waitrequest=0) in the same cycle: acceptance governs; start ignored.
REQ-030 A full 32-bit compare SHALL be used; no masking of either word.

Reset
REQ-031 reset=1 SHALL force IDLE and m_read=0, m_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout=0, wait counter=0, captured_id=0, captured_ts=0.
REQ-032 Reset asserted mid-read SHALL abort on the next edge with m_read=0; no partial result is reported.
REQ-033 With AUTO_START=1, a sequence SHALL launch on the first cycle after reset deasserts, even if start=0.

Verification
REQ-034 Zero-wait slave returning 0 at addr0 and 1642426435 at addr1, AUTO_START=1 -> done=1 on the 4th post-reset cycle, pass=1, id_ok=1, ts_ok=1, timeout=0.
REQ-035 Addr1 returns 32'h61E57042 -> done=1, id_ok=1, ts_ok=0, pass=0, captured_ts=32'h61E57042.
REQ-036 m_waitrequest=1 for 3 cycles on each read -> m_read/m_address stable while stalled, done=1 on the 10th cycle, pass=1.
REQ-037 m_waitrequest stuck 1 on addr0, TIMEOUT_CYCLES=16 -> m_read drops after 16 stalled cycles, timeout=1, id_ok=0, ts_ok=0, pass=0, addr1 never read.
REQ-038 Reset pulsed during RD_TS stall -> next cycle all outputs at reset values; with AUTO_START=0 no read until start=1, then a normal pass.
REQ-039 start pulsed in DONE after a failing run -> done=0 and pass=0 next cycle, new sequence runs and reports the new result.
